// File: rtl/umi_regbank.sv
// -----------------------------------------------------------------------------
// umi_regbank
//
// Register bank fed by the UMI register interface (reg_* bus). It decodes
// single-beat reads and writes into a fixed register map:
//   0 ID (read-only), 1 CTRL, 2 STATUS (sticky, write-1-to-clear),
//   3 IRQMASK, 4 COUNTER (loadable, free-running when CTRL[0]=1),
//   5..NREG-1 general purpose.
// Read data is registered and held until the next read.
//
// Ports:
//   clk, nreset       clock, asynchronous active-low reset
//   reg_addr          byte address; index and byte offset are taken from it
//   reg_write         write strobe, one cycle per access
//   reg_read          read strobe, one cycle per access
//   reg_size          access size, 2^reg_size bytes
//   reg_len           transfer count minus one (only 0 is legal)
//   reg_wrdata        write data, byte-lane aligned to the address
//   reg_rddata        registered read data, held between reads
//   hw_event          event inputs that set STATUS[2 +: NEV]
//   ctrl              CTRL register contents
//   gpreg             GP registers 5..NREG-1 concatenated, register 5 in LSBs
//   irq               registered |(STATUS & IRQMASK)
// -----------------------------------------------------------------------------
module umi_regbank #(
    parameter int              AW    = 64,
    parameter int              RW    = 64,
    parameter int              NREG  = 16,
    parameter int              NEV   = 8,
    parameter logic [RW-1:0]   IDVAL = '0
) (
    input  logic                     clk,
    input  logic                     nreset,
    input  logic [AW-1:0]            reg_addr,
    input  logic                     reg_write,
    input  logic                     reg_read,
    input  logic [2:0]               reg_size,
    input  logic [7:0]               reg_len,
    input  logic [RW-1:0]            reg_wrdata,
    output logic [RW-1:0]            reg_rddata,
    input  logic [NEV-1:0]           hw_event,
    output logic [RW-1:0]            ctrl,
    output logic [(NREG-5)*RW-1:0]   gpreg,
    output logic                     irq
);

    localparam int ALSB  = $clog2(RW / 8);
    localparam int IW    = $clog2(NREG);
    localparam int NB    = RW / 8;
    localparam int NGP   = NREG - 5;
    localparam int NSTAT = 2 + NEV;

    logic [IW-1:0]           index;
    logic [ALSB-1:0]         offset;
    logic                    legal;
    logic [RW-1:0]           wmask;
    logic [RW-1:0]           wdata_m;
    logic                    wr_ok;
    logic                    err_pulse;
    logic                    cnt_wr;
    logic                    ovf_pulse;
    logic [NSTAT-1:0]        status;
    logic [NSTAT-1:0]        w1c_mask;
    logic [NSTAT-1:0]        set_vec;
    logic [RW-1:0]           irqmask;
    logic [RW-1:0]           counter;
    logic [NGP-1:0][RW-1:0]  gp;
    logic [IW-1:0]           gp_sel;
    logic [RW-1:0]           rd_val;

    assign index  = reg_addr[ALSB +: IW];
    assign offset = reg_addr[ALSB-1:0];
    assign gp_sel = index - IW'(5);

    // Legality check and byte-lane mask for the current access.
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        int sz;
        int off;
        sz    = 1 << int'(reg_size);
        off   = int'(offset);
        legal = (int'(reg_size) <= ALSB) && ((off & (sz - 1)) == 0) &&
                (reg_len == 8'd0);
        wmask = '0;
        for (int b = 0; b < NB; b++) begin
            wmask[b*8 +: 8] = {8{legal && (b >= off) && (b < off + sz)}};
        end
    end

    assign wdata_m   = reg_wrdata & wmask;
    assign wr_ok     = reg_write & legal;
    assign err_pulse = (reg_write | reg_read) & ~legal;
    assign cnt_wr    = wr_ok && (index == IW'(4));
    // Overflow only on a real increment: a load in the same cycle suppresses it.
    assign ovf_pulse = ~cnt_wr & ctrl[0] & (&counter);
    assign w1c_mask  = (wr_ok && index == IW'(2)) ? wdata_m[NSTAT-1:0] : '0;
    assign set_vec   = {hw_event, ovf_pulse, err_pulse};

    // Byte-enabled merge of the write data into an existing register value.
    function automatic logic [RW-1:0] merge(input logic [RW-1:0] old);
        return (old & ~wmask) | wdata_m;
    endfunction

    // Full-width read value, independent of access size and offset.
    always_comb begin
        rd_val = '0;
        case (int'(index))
            0:       rd_val = IDVAL;
            1:       rd_val = ctrl;
            2:       rd_val = RW'(status);
            3:       rd_val = irqmask;
            4:       rd_val = counter;
            default: rd_val = gp[gp_sel];
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // right-hand side sees pre-edge values (reads return pre-write data).
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            reg_rddata <= '0;
            ctrl       <= '0;
            status     <= '0;
            irqmask    <= '0;
            counter    <= '0;
            // NOTE: the GP array is a handful of flops with a defined reset
            // value, not a RAM, so it is cleared along with everything else.
            gp         <= '0;
            irq        <= 1'b0;
        end else begin
            if (reg_read) begin
                reg_rddata <= legal ? rd_val : '0;
            end
            if (wr_ok && index == IW'(1)) begin
                ctrl <= merge(ctrl);
            end
            if (wr_ok && index == IW'(3)) begin
                irqmask <= merge(irqmask);
            end
            if (cnt_wr) begin
                counter <= merge(counter);
            end else if (ctrl[0]) begin
                counter <= counter + RW'(1);
            end
            // Set wins over a same-cycle clear.
            status <= (status & ~w1c_mask) | set_vec;
            for (int i = 0; i < NGP; i++) begin
                if (wr_ok && index == IW'(i + 5)) begin
                    gp[i] <= merge(gp[i]);
                end
            end
            irq <= |(RW'(status) & irqmask);
        end
    end

    assign gpreg = gp;

endmodule

// File: tb/tb_umi_regbank.sv
// -----------------------------------------------------------------------------
// tb_umi_regbank
//
// Directed self-checking bench for umi_regbank with default parameters
// (AW=64, RW=64, NREG=16, NEV=8, IDVAL=0). Inputs change on the falling edge,
// outputs are sampled on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_umi_regbank;

    logic         clk;
    logic         nreset;
    logic [63:0]  reg_addr;
    logic         reg_write;
    logic         reg_read;
    logic [2:0]   reg_size;
    logic [7:0]   reg_len;
    logic [63:0]  reg_wrdata;
    logic [63:0]  reg_rddata;
    logic [7:0]   hw_event;
    logic [63:0]  ctrl;
    logic [703:0] gpreg;
    logic         irq;

    int n_pass  = 0;
    int n_total = 0;

    umi_regbank dut (
        .clk        (clk),
        .nreset     (nreset),
        .reg_addr   (reg_addr),
        .reg_write  (reg_write),
        .reg_read   (reg_read),
        .reg_size   (reg_size),
        .reg_len    (reg_len),
        .reg_wrdata (reg_wrdata),
        .reg_rddata (reg_rddata),
        .hw_event   (hw_event),
        .ctrl       (ctrl),
        .gpreg      (gpreg),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called at a falling edge; the access is sampled by the next rising edge.
    task automatic wr(input logic [63:0] addr, input logic [2:0] size, input logic [63:0] data);
        reg_addr   = addr;
        reg_size   = size;
        reg_wrdata = data;
        reg_write  = 1'b1;
        @(negedge clk);
        reg_write  = 1'b0;
    endtask

    task automatic rd(input logic [63:0] addr);
        reg_addr = addr;
        reg_size = 3'd3;
        reg_read = 1'b1;
        @(negedge clk);
        reg_read = 1'b0;
    endtask

    initial begin
        nreset     = 1'b0;
        reg_addr   = '0;
        reg_write  = 1'b0;
        reg_read   = 1'b0;
        reg_size   = 3'd3;
        reg_len    = 8'd0;
        reg_wrdata = '0;
        hw_event   = '0;

        // Reset state
        #1;
        check("rst_rddata", reg_rddata, 64'h0);
        check("rst_ctrl",   ctrl,       64'h0);
        check("rst_gpreg5", gpreg[63:0], 64'h0);
        check("rst_irq",    {63'h0, irq}, 64'h0);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);

        // Read indices 0..4 after reset
        for (int i = 0; i < 5; i++) begin
            rd(64'(i * 8));
            check($sformatf("rst_read_idx%0d", i), reg_rddata, 64'h0);
        end

        // Byte write to byte 3 of GP register 5; other lanes carry junk
        wr(64'd43, 3'd0, 64'hFFFF_FFFF_A5FF_FFFF);
        check("byte_wr_gpreg", gpreg[63:0], 64'h0000_0000_A500_0000);
        rd(64'd40);
        check("byte_wr_read", reg_rddata, 64'h0000_0000_A500_0000);

        // Illegal write: size 2 at offset 2 of register 6
        wr(64'd50, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        check("illegal_wr_gp6", gpreg[127:64], 64'h0);
        rd(64'd16);
        check("illegal_status", reg_rddata, 64'h1);
        check("irq_masked", {63'h0, irq}, 64'h0);

        // Unmask error bit: irq follows one cycle after the mask write
        wr(64'd24, 3'd3, 64'h1);
        check("irq_lag", {63'h0, irq}, 64'h0);
        @(negedge clk);
        check("irq_set", {63'h0, irq}, 64'h1);

        // W1C the error bit: irq drops one cycle after the clear
        wr(64'd16, 3'd3, 64'h1);
        check("irq_hold_after_w1c", {63'h0, irq}, 64'h1);
        @(negedge clk);
        check("irq_clear", {63'h0, irq}, 64'h0);

        // Counter wrap: load near all-ones, then enable
        wr(64'd32, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE);
        wr(64'd8, 3'd3, 64'h1);
        check("ctrl_out", ctrl, 64'h1);
        rd(64'd32);
        check("cnt_fe", reg_rddata, 64'hFFFF_FFFF_FFFF_FFFE);
        rd(64'd32);
        check("cnt_ff", reg_rddata, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(64'd32);
        check("cnt_wrap", reg_rddata, 64'h0);
        rd(64'd16);
        check("ovf_status", reg_rddata, 64'h2);
        wr(64'd16, 3'd3, 64'h2);

        // Counter load while enabled: no increment on the load cycle
        wr(64'd32, 3'd3, 64'h100);
        rd(64'd32);
        check("cnt_load_no_inc", reg_rddata, 64'h100);
        rd(64'd32);
        check("cnt_inc_after_load", reg_rddata, 64'h101);
        wr(64'd8, 3'd3, 64'h0);

        // ID is read-only and a write to it is not an error
        wr(64'd0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        rd(64'd0);
        check("id_readonly", reg_rddata, 64'h0);
        rd(64'd16);
        check("id_wr_no_err", reg_rddata, 64'h0);

        // Event set wins over same-cycle W1C; later W1C clears it
        hw_event = 8'h01;
        wr(64'd16, 3'd3, 64'h4);
        hw_event = 8'h00;
        rd(64'd16);
        check("event_beats_clear", reg_rddata, 64'h4);
        wr(64'd16, 3'd3, 64'h4);
        rd(64'd16);
        check("event_cleared", reg_rddata, 64'h0);

        // Simultaneous read and write returns the pre-write value
        wr(64'd64, 3'd3, 64'h1111);
        reg_addr   = 64'd64;
        reg_size   = 3'd3;
        reg_wrdata = 64'h2222;
        reg_write  = 1'b1;
        reg_read   = 1'b1;
        @(negedge clk);
        reg_write  = 1'b0;
        reg_read   = 1'b0;
        check("rw_pre_write", reg_rddata, 64'h1111);
        check("rw_gpreg8", gpreg[255:192], 64'h2222);

        // Read data holds with no further reads
        wr(64'd56, 3'd3, 64'h1234);
        rd(64'd56);
        repeat (10) @(negedge clk);
        check("rddata_hold", reg_rddata, 64'h1234);

        // Illegal read (reg_len != 0) returns 0 and flags an error
        reg_len = 8'd1;
        rd(64'd40);
        reg_len = 8'd0;
        check("illegal_read_zero", reg_rddata, 64'h0);
        rd(64'd16);
        check("illegal_read_status", reg_rddata, 64'h1);
        check("irq_from_rd_err", {63'h0, irq}, 64'h1);

        // Asynchronous reset in the middle of an access
        wr(64'd8, 3'd3, 64'h1);
        rd(64'd56);
        reg_addr   = 64'd72;
        reg_wrdata = 64'hDEAD;
        reg_write  = 1'b1;
        #2;
        nreset = 1'b0;
        #1;
        check("midrst_rddata", reg_rddata, 64'h0);
        check("midrst_ctrl",   ctrl,       64'h0);
        check("midrst_gpreg5", gpreg[63:0], 64'h0);
        check("midrst_gpreg9", gpreg[319:256], 64'h0);
        check("midrst_irq",    {63'h0, irq}, 64'h0);
        @(negedge clk);
        reg_write = 1'b0;
        nreset    = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
